// File: rtl/sr_reset_sequencer.sv
// Reset/set pin sequencer for a bank of async set/reset flops: synchronous release, fixed-width pulses, recovery before ready.
// Optional timing-violation handling (notifier, viol_o) is enabled with `define SR_SEQ_NOTIFIER_EN.
module sr_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic req_set,
  input  logic req_clr,
  output logic srn_o,
  output logic rrn_o,
  output logic ready,
  output logic ack,
  output logic err
`ifdef SR_SEQ_NOTIFIER_EN
  ,
  input  logic notifier,
  output logic viol_o
`endif
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    ST_RST, ST_SYNC, ST_HOLD_R, ST_RECOVER, ST_IDLE, ST_SET_A, ST_CLR_A
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-2:0] rst_sync_q, rst_sync_d;
  logic srn_q, srn_d, rrn_q, rrn_d, ready_q, ready_d;
  logic ack_q, ack_d, err_q, err_d;
  logic ack_en_q, ack_en_d, force_q, force_d;
  logic viol_det;

`ifdef SR_SEQ_NOTIFIER_EN
  logic [SYNC_STAGES-1:0] ntf_sync_q, ntf_sync_d;
  logic ntf_prev_q, ntf_prev_d, viol_q, viol_d;

  always_comb begin
    ntf_sync_d = {ntf_sync_q[SYNC_STAGES-2:0], notifier};
    ntf_prev_d = ntf_sync_q[SYNC_STAGES-1];
    viol_det   = ntf_sync_q[SYNC_STAGES-1] ^ ntf_prev_q;
    viol_d     = viol_q | viol_det;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ntf_sync_q <= '0;
      ntf_prev_q <= 1'b0;
      viol_q     <= 1'b0;
    end else begin
      ntf_sync_q <= ntf_sync_d;
      ntf_prev_q <= ntf_prev_d;
      viol_q     <= viol_d;
    end
  end

  assign viol_o = viol_q;
`else
  assign viol_det = 1'b0;
`endif

  // The RST state register acts as the last stage of the RESETN release synchronizer.
  always_comb begin
    rst_sync_d[0] = 1'b1;
    for (int i = 1; i < SYNC_STAGES - 1; i++) rst_sync_d[i] = rst_sync_q[i-1];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_en_d = ack_en_q;
    force_d  = force_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_RST: begin
        if (rst_sync_q[SYNC_STAGES-2]) begin
          state_d = ST_SYNC;
          cnt_d   = HOLD_LD;
        end
      end
      // SYNC counts as the first of the HOLD_CYCLES release-hold cycles.
      ST_SYNC, ST_HOLD_R: begin
        if (cnt_q <= CNT_ONE) begin
          state_d  = ST_RECOVER;
          cnt_d    = '0;
          ack_en_d = 1'b0;
          force_d  = 1'b0;
        end else begin
          state_d = ST_HOLD_R;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (viol_det || force_q) begin
          state_d  = ST_CLR_A;
          cnt_d    = HOLD_LD;
          ack_en_d = 1'b0;
          force_d  = 1'b0;
        end else begin
          state_d  = ST_IDLE;
          ack_d    = ack_en_q;
          ack_en_d = 1'b0;
        end
      end
      ST_IDLE: begin
        err_d = req_set & req_clr;
        cnt_d = HOLD_LD;
        if (viol_det) begin
          state_d  = ST_CLR_A;
          ack_en_d = 1'b0;
        end else if (req_clr) begin
          state_d  = ST_CLR_A;
          ack_en_d = 1'b1;
        end else if (req_set) begin
          state_d  = ST_SET_A;
          ack_en_d = 1'b1;
        end
      end
      ST_SET_A: begin
        if (viol_det) begin
          // Release the set pin first so set and reset never overlap.
          state_d  = ST_RECOVER;
          cnt_d    = '0;
          force_d  = 1'b1;
          ack_en_d = 1'b0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CLR_A: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_RST;
    endcase

    srn_d   = (state_d != ST_SET_A);
    rrn_d   = !(state_d inside {ST_RST, ST_SYNC, ST_HOLD_R, ST_CLR_A});
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_RST;
      cnt_q      <= '0;
      rst_sync_q <= '0;
      srn_q      <= 1'b1;
      rrn_q      <= 1'b0;
      ready_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ack_en_q   <= 1'b0;
      force_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_sync_q <= rst_sync_d;
      srn_q      <= srn_d;
      rrn_q      <= rrn_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ack_en_q   <= ack_en_d;
      force_q    <= force_d;
    end
  end

  assign srn_o = srn_q;
  assign rrn_o = rrn_q;
  assign ready = ready_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sr_reset_sequencer.sv
// Self-checking bench for sr_reset_sequencer: timeline reference model driven by directed and random requests.
module tb_sr_reset_sequencer;
  localparam int S = 2;
  localparam int H = 4;

  logic CLK = 1'b0;
  logic RESETN, req_set, req_clr;
  logic srn_o, rrn_o, ready, ack, err;
`ifdef SR_SEQ_NOTIFIER_EN
  logic notifier, viol_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Model: t = edge index since release (E0 = 0); pulses described by start edge and kind.
  int t, next_sample, p_start, p_kind, err_at;

  sr_reset_sequencer #(.SYNC_STAGES(S), .HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RESETN(RESETN), .req_set(req_set), .req_clr(req_clr),
    .srn_o(srn_o), .rrn_o(rrn_o), .ready(ready), .ack(ack), .err(err)
`ifdef SR_SEQ_NOTIFIER_EN
    , .notifier(notifier), .viol_o(viol_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t = -1;
    next_sample = S + H + 1;
    p_start = -100;
    p_kind = 0;
    err_at = -100;
  endtask

  task automatic check_in_reset(input string tag);
    chk({tag, "_srn"}, srn_o, 1'b1);
    chk({tag, "_rrn"}, rrn_o, 1'b0);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_ack"}, ack, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
`ifdef SR_SEQ_NOTIFIER_EN
    chk({tag, "_viol"}, viol_o, 1'b0);
`endif
  endtask

  // Called at a negedge; drops RESETN between clock edges and checks the immediate response.
  task automatic do_reset(input int cycles);
    RESETN = 1'b0;
    #1;
    check_in_reset("rst_async");
    repeat (cycles) begin
      @(negedge CLK);
      check_in_reset("rst_hold");
    end
    RESETN = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic s, input logic c);
    logic in_pulse;
    req_set = s;
    req_clr = c;
    t++;
    if (t == next_sample) begin
      if (s && c) err_at = t;
      if (c) begin
        p_kind = 2; p_start = t; next_sample = t + H + 2;
      end else if (s) begin
        p_kind = 1; p_start = t; next_sample = t + H + 2;
      end else begin
        next_sample = t + 1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    in_pulse = (p_start >= 0) && (t >= p_start) && (t < p_start + H);
    chk("srn", srn_o, !(in_pulse && p_kind == 1));
    chk("rrn", rrn_o, (t >= S + H - 1) && !(in_pulse && p_kind == 2));
    chk("ready", ready, (t >= S + H) && !((p_start >= 0) && (t >= p_start) && (t <= p_start + H)));
    chk("ack", ack, (p_start >= 0) && (t == p_start + H + 1));
    chk("err", err, t == err_at);
    chk("excl", srn_o | rrn_o, 1'b1);
  endtask

  task automatic run_to_sample();
    for (int i = 0; i < 20 && (t + 1) != next_sample; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    RESETN = 1'b0;
    req_set = 1'b0;
    req_clr = 1'b0;
`ifdef SR_SEQ_NOTIFIER_EN
    notifier = 1'b0;
`endif
    model_reset();
    @(negedge CLK);
    do_reset(3);

    // Power-up release, then a single set request sampled at E20.
    while (t < 19) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);

    // Both requests in IDLE: clear wins, err pulses.
    run_to_sample();
    step(1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b0);

    // Held clear request repeats its pulse.
    repeat (30) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);

    // Reset dropped during the second cycle of a set pulse.
    run_to_sample();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    do_reset(3);
    repeat (10) step(1'b0, 1'b0);

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);

`ifdef SR_SEQ_NOTIFIER_EN
    // Notifier toggle during SET_A: forced clear follows, no ack, sticky viol_o.
    repeat (8) step(1'b0, 1'b0);
    run_to_sample();
    step(1'b1, 1'b0);
    req_set = 1'b0;
    notifier = ~notifier;
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("ntf_viol", viol_o, k >= 3);
      chk("ntf_srn", srn_o, k >= 3);
      chk("ntf_rrn", rrn_o, !(k >= 4 && k <= 7));
      chk("ntf_ready", ready, k >= 9);
      chk("ntf_ack", ack, 1'b0);
    end
    do_reset(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
